// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: GPR commit, minimal CSR file, ERTN flush, trace port
module wb_stage #(
  parameter int MEM_WB_W = 151,
  parameter int WB_ID_W  = 38
) (
  input  logic                clk,
  input  logic                reset,
  output logic                wb_allowin,
  input  logic                mem_to_wb_valid,
  input  logic [MEM_WB_W-1:0] mem_to_wb_bus,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [WB_ID_W-1:0]  wb_to_id_bus,
  output logic                ertn_flush,
  output logic [31:0]         ertn_pc,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_EENTRY = 14'hc;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;

  logic                wb_valid;
  logic                wb_ready_go;
  logic [MEM_WB_W-1:0] payload;

  logic        p_rf_we;
  logic [4:0]  p_rf_waddr;
  logic [31:0] p_rf_wdata;
  logic [31:0] p_pc;
  logic        p_csr_re;
  logic        p_csr_we;
  logic [13:0] p_csr_num;
  logic [31:0] p_csr_wmask;
  logic [31:0] p_csr_wvalue;
  logic        p_ertn;

  assign {p_rf_we, p_rf_waddr, p_rf_wdata, p_pc, p_csr_re, p_csr_we,
          p_csr_num, p_csr_wmask, p_csr_wvalue, p_ertn} = payload;

  logic        crmd_da, crmd_ie;
  logic [1:0]  crmd_plv;
  logic        prmd_pie;
  logic [1:0]  prmd_pplv;
  logic [31:0] era;
  logic [25:0] eentry_va;
  logic [31:0] save0, save1, save2, save3;

  logic [31:0] csr_rvalue;
  logic [31:0] csr_new;
  logic        csr_wr;

  assign wb_ready_go = 1'b1;
  assign wb_allowin  = ~wb_valid | wb_ready_go;
  assign ertn_flush  = wb_valid & p_ertn;
  assign ertn_pc     = era;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      payload  <= '0;
    end else begin
      wb_valid <= mem_to_wb_valid & wb_allowin & ~ertn_flush;
      if (mem_to_wb_valid & wb_allowin)
        payload <= mem_to_wb_bus;
    end
  end

  always_comb begin
    csr_rvalue = 32'b0;
    case (p_csr_num)
      CSR_CRMD:   csr_rvalue = {28'b0, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd_pie, prmd_pplv};
      CSR_ERA:    csr_rvalue = era;
      CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
      CSR_SAVE0:  csr_rvalue = save0;
      CSR_SAVE1:  csr_rvalue = save1;
      CSR_SAVE2:  csr_rvalue = save2;
      CSR_SAVE3:  csr_rvalue = save3;
      default:    csr_rvalue = 32'b0;
    endcase
  end

  // Read and write share csr_num, so the read value is also the old value to merge with.
  assign csr_new = (csr_rvalue & ~p_csr_wmask) | (p_csr_wvalue & p_csr_wmask);
  assign csr_wr  = wb_valid & p_csr_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_da   <= 1'b1;
      crmd_ie   <= 1'b0;
      crmd_plv  <= 2'b0;
      prmd_pie  <= 1'b0;
      prmd_pplv <= 2'b0;
      era       <= 32'b0;
      eentry_va <= 26'b0;
      save0     <= 32'b0;
      save1     <= 32'b0;
      save2     <= 32'b0;
      save3     <= 32'b0;
    end else begin
      if (csr_wr) begin
        case (p_csr_num)
          CSR_CRMD:   {crmd_da, crmd_ie, crmd_plv} <= csr_new[3:0];
          CSR_PRMD:   {prmd_pie, prmd_pplv} <= csr_new[2:0];
          CSR_ERA:    era <= csr_new;
          CSR_EENTRY: eentry_va <= csr_new[31:6];
          CSR_SAVE0:  save0 <= csr_new;
          CSR_SAVE1:  save1 <= csr_new;
          CSR_SAVE2:  save2 <= csr_new;
          CSR_SAVE3:  save3 <= csr_new;
          default:    ;
        endcase
      end
      // Placed after the CSR write so the ERTN restore overrides a same-instruction CRMD write.
      if (ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end
    end
  end

  assign rf_we    = wb_valid & p_rf_we;
  assign rf_waddr = p_rf_waddr;
  assign rf_wdata = p_csr_re ? csr_rvalue : p_rf_wdata;

  assign wb_to_id_bus      = {rf_we, rf_waddr, rf_wdata};
  assign debug_wb_pc       = p_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - vector table plus scoreboard bench for wb_stage
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [150:0] mem_to_wb_bus;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [37:0]  wb_to_id_bus;
  logic         ertn_flush;
  logic [31:0]  ertn_pc;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_we;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_stage #(.MEM_WB_W(151), .WB_ID_W(38)) dut (
    .clk(clk), .reset(reset), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_bus(mem_to_wb_bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_to_id_bus(wb_to_id_bus), .ertn_flush(ertn_flush), .ertn_pc(ertn_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic         valid;
    logic [150:0] bus;
    logic         exp_we;
    logic [4:0]   exp_wnum;
    logic [31:0]  exp_wdata;
    logic [31:0]  exp_pc;
    logic         exp_flush;
    logic [31:0]  exp_epc;
  } vec_t;

  vec_t tbl[18];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] ONES = 32'hffff_ffff;
  localparam logic [31:0] RA   = 32'h1c00_0100;

  function automatic vec_t mk(input logic v, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic re, input logic cwe, input logic [13:0] num,
                              input logic [31:0] m, input logic [31:0] val, input logic er,
                              input logic xwe, input logic [31:0] xwd,
                              input logic xfl, input logic [31:0] xepc);
    vec_t r;
    r.valid     = v;
    r.bus       = {we, wa, wd, pc, re, cwe, num, m, val, er};
    r.exp_we    = xwe;
    r.exp_wnum  = wa;
    r.exp_wdata = xwd;
    r.exp_pc    = pc;
    r.exp_flush = xfl;
    r.exp_epc   = xepc;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    mem_to_wb_valid = v.valid;
    mem_to_wb_bus   = v.bus;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check("rf_we", {63'b0, rf_we}, {63'b0, e.exp_we});
      check("debug_wb_rf_we", {60'b0, debug_wb_rf_we}, {60'b0, {4{e.exp_we}}});
      check("fwd_we", {63'b0, wb_to_id_bus[37]}, {63'b0, e.exp_we});
      check("ertn_flush", {63'b0, ertn_flush}, {63'b0, e.exp_flush});
      check("ertn_pc", {32'b0, ertn_pc}, {32'b0, e.exp_epc});
      if (e.exp_we) begin
        check("rf_wnum", {59'b0, debug_wb_rf_wnum}, {59'b0, e.exp_wnum});
        check("rf_wdata", {32'b0, rf_wdata}, {32'b0, e.exp_wdata});
        check("debug_wdata", {32'b0, debug_wb_rf_wdata}, {32'b0, e.exp_wdata});
        check("debug_pc", {32'b0, debug_wb_pc}, {32'b0, e.exp_pc});
        check("fwd_bus", {26'b0, wb_to_id_bus}, {26'b0, 1'b1, e.exp_wnum, e.exp_wdata});
      end
    end
  endtask

  function automatic logic [31:0] pcn(input int i);
    return 32'h1c00_0010 + 32'(4 * i);
  endfunction

  initial begin
    tbl[0]  = mk(1, 1, 5'd5, 32'h1234_5678, pcn(0), 0, 0, 14'h0, 0, 0, 0, 1, 32'h1234_5678, 0, 0);
    tbl[1]  = mk(1, 0, 5'd0, 0, pcn(1), 0, 1, 14'h30, ONES, 32'hffff_0000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 5'd6, 0, pcn(2), 1, 1, 14'h30, 32'h0000_ffff, 32'h1234_abcd, 0, 1, 32'hffff_0000, 0, 0);
    tbl[3]  = mk(1, 1, 5'd7, 0, pcn(3), 1, 0, 14'h30, 0, 0, 0, 1, 32'hffff_abcd, 0, 0);
    tbl[4]  = mk(1, 0, 5'd0, 0, pcn(4), 0, 1, 14'h1, ONES, ONES, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 5'd8, 0, pcn(5), 1, 1, 14'h6, ONES, RA, 0, 1, 32'h0, 0, 0);
    tbl[6]  = mk(1, 1, 5'd9, 0, pcn(6), 1, 0, 14'h0, 0, 0, 0, 1, 32'h8, 0, RA);
    tbl[7]  = mk(1, 1, 5'd10, 0, pcn(7), 1, 0, 14'h1, 0, 0, 0, 1, 32'h7, 0, RA);
    tbl[8]  = mk(1, 0, 5'd0, 0, pcn(8), 0, 0, 14'h0, 0, 0, 1, 0, 0, 1, RA);
    tbl[9]  = mk(1, 1, 5'd11, 32'hdead_beef, pcn(9), 0, 0, 14'h0, 0, 0, 0, 0, 0, 0, RA);
    tbl[10] = mk(1, 1, 5'd12, 0, pcn(10), 1, 0, 14'h0, 0, 0, 0, 1, 32'hf, 0, RA);
    tbl[11] = mk(1, 0, 5'd0, 0, pcn(11), 0, 1, 14'h5, ONES, ONES, 0, 0, 0, 0, RA);
    tbl[12] = mk(1, 1, 5'd13, 32'h5555_5555, pcn(12), 1, 0, 14'h5, 0, 0, 0, 1, 32'h0, 0, RA);
    tbl[13] = mk(1, 1, 5'd14, 0, pcn(13), 1, 0, 14'h30, 0, 0, 0, 1, 32'hffff_abcd, 0, RA);
    tbl[14] = mk(1, 1, 5'd15, 0, pcn(14), 1, 0, 14'h6, 0, 0, 0, 1, RA, 0, RA);
    tbl[15] = mk(1, 0, 5'd0, 0, pcn(15), 0, 1, 14'hc, ONES, ONES, 0, 0, 0, 0, RA);
    tbl[16] = mk(1, 1, 5'd16, 0, pcn(16), 1, 0, 14'hc, 0, 0, 0, 1, 32'hffff_ffc0, 0, RA);
    tbl[17] = mk(0, 1, 5'd17, 32'h1111_1111, pcn(17), 0, 0, 14'h0, 0, 0, 0, 0, 0, 0, RA);

    reset = 1'b1;
    mem_to_wb_valid = 1'b0;
    mem_to_wb_bus = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_rf_we", {63'b0, rf_we}, 64'd0);
    check("rst_flush", {63'b0, ertn_flush}, 64'd0);
    check("rst_ertn_pc", {32'b0, ertn_pc}, 64'd0);
    check("rst_allowin", {63'b0, wb_allowin}, 64'd1);
    check("rst_debug", {debug_wb_pc, debug_wb_rf_wdata}, 64'd0);
    check("rst_debug_we_wnum", {55'b0, debug_wb_rf_we, debug_wb_rf_wnum}, 64'd0);
    check("rst_fwd", {26'b0, wb_to_id_bus}, 64'd0);

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // Mid-operation reset: SAVE1 write commits, then an in-flight GPR write is lost.
    apply(mk(1, 0, 5'd0, 0, pcn(20), 0, 1, 14'h31, ONES, 32'h55, 0, 0, 0, 0, RA));
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus = tbl[0].bus;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_rf_we", {63'b0, rf_we}, 64'd0);
    check("midrst_era", {32'b0, ertn_pc}, 64'd0);
    mem_to_wb_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    apply(mk(1, 1, 5'd20, 0, pcn(21), 1, 0, 14'h31, 0, 0, 0, 1, 32'h0, 0, 0));
    apply(mk(1, 1, 5'd21, 0, pcn(22), 1, 0, 14'h0, 0, 0, 0, 1, 32'h8, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
